seq_deser: RTL and testbench

Serial-to-parallel frame collector that consumes the 1-bit registered stream produced by the sequential pipeline stage (its `d_out` drives this block's `d_in`). It waits for a start bit, shifts in `WIDTH` data bits LSB-first, optionally checks an even-parity bit, then presents the word with a one-cycle valid pulse. It is the first stage of the design that is wider than one bit.

---
 rtl/seq_deser.sv | 140 ++++++++++++++
 tb/tb_seq_deser.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_deser.sv
// ============================================================================
// Module      : seq_deser
// Description : Serial-to-parallel frame collector. Waits for a start bit and
//               shifts in WIDTH data bits LSB-first. Optionally checks an even
//               parity bit (SEQ_DESER_PARITY_EN). Presents each completed word
//               with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             busy
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef SEQ_DESER_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_DATA   = 2'd1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [WIDTH-1:0]   w_shifted;

`ifdef SEQ_DESER_PARITY_EN
    logic               r_perr;
    logic               w_perr_nxt;
`endif

    assign w_shifted = {d_in, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef SEQ_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
`ifdef SEQ_DESER_PARITY_EN
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bit_en && d_in) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    w_shreg_nxt = w_shifted;
                    if (r_cnt == c_cnt_last) begin
`ifdef SEQ_DESER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_IDLE;
                        w_data_nxt  = w_shifted;
                        w_valid_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
`ifdef SEQ_DESER_PARITY_EN
            S_PARITY: begin
                // Even parity: the parity bit plus all data bits XOR to zero.
                if (bit_en) begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = r_shreg;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = d_in ^ (^r_shreg);
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state != S_IDLE);
`ifdef SEQ_DESER_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_deser.sv
// ============================================================================
// Module      : tb_seq_deser
// Description : Self-checking bench for seq_deser. It runs directed frames and
//               then random traffic against a frame-level reference model.
//               It honours SEQ_DESER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_deser;

    localparam int WIDTH = 8;
`ifdef SEQ_DESER_PARITY_EN
    localparam bit c_par = 1'b1;
`else
    localparam bit c_par = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d_in = 1'b0;
    logic             bit_en = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: whether a frame is open, how many data bits it has so far,
    // and the word built from those bits.
    bit               m_busy  = 1'b0;
    int               m_idx   = 0;
    logic [WIDTH-1:0] m_acc   = '0;
    logic [WIDTH-1:0] m_out   = '0;
    bit               m_valid = 1'b0;
    bit               m_perr  = 1'b0;

    seq_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit d);
        m_valid = 1'b0;
        m_perr  = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_acc  = '0;
            m_out  = '0;
        end else if (e) begin
            if (!m_busy) begin
                if (d) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end else if (m_idx < WIDTH) begin
                m_acc[m_idx] = d;
                m_idx++;
                if (m_idx == WIDTH && !c_par) begin
                    m_out   = m_acc;
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
            end else begin
                m_out   = m_acc;
                m_valid = 1'b1;
                m_perr  = (d != ^m_acc);
                m_busy  = 1'b0;
            end
        end
    endtask

    // One clock: apply inputs, let the edge happen, then compare everything.
    task automatic step(input bit r, input bit e, input bit d);
        rst    = r;
        bit_en = e;
        d_in   = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("data_out",   32'(data_out),   32'(m_out));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("busy",       32'(busy),       32'(m_busy));
    endtask

    // Sends start, data LSB-first and (if compiled in) a parity bit.
    // With toggle set, an idle bit_en=0 cycle carrying random d_in precedes each bit.
    task automatic send_frame(input logic [WIDTH-1:0] word, input bit bad_par, input bit toggle);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            if (toggle) step(1'b0, 1'b0, 1'($urandom_range(1)));
            step(1'b0, 1'b1, word[i]);
        end
        if (c_par) begin
            if (toggle) step(1'b0, 1'b0, 1'($urandom_range(1)));
            step(1'b0, 1'b1, (^word) ^ bad_par);
        end
        check("frame_valid", 32'(data_valid), 32'd1);
        check("frame_word",  32'(data_out),   32'(word));
        check("frame_perr",  32'(parity_err), 32'(c_par & bad_par));
    endtask

    initial begin
        // Reset held with an apparent start bit on the line.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("valid_single_pulse", 32'(data_valid), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Back-to-back: second start bit lands in the valid cycle of the first.
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Abort after four data bits.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'($urandom_range(1)));
        step(1'b1, 1'b1, 1'b1);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_dout",  32'(data_out), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            send_frame(WIDTH'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
            for (int g = 0; g < int'($urandom_range(2)); g++) step(1'b0, 1'b1, 1'b0);
        end

        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
